// File: rtl/reg_file_bypass.sv
// reg_file_bypass: 2-write / 2-read register file for the MIPS datapath.
// After reset a sequencer walks every register and writes it to zero before
// raising ready. Write port 1 (load return) has priority over port 0
// (writeback) when both target the same register. A busy bit per register
// tracks outstanding producers for hazard detection in decode.
// Optional macro RF_BYPASS_EN: same-cycle write data (and busy clear) is
// forwarded to the read ports. Without it, reads see stored state only.
module reg_file_bypass #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  wen0,
    input  logic [ADDR_WIDTH-1:0] waddr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  wen1,
    input  logic [ADDR_WIDTH-1:0] waddr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic                  set_busy,
    input  logic [ADDR_WIDTH-1:0] busy_addr,
    output logic                  busy1,
    output logic                  busy2
);

    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    ready_q;
    logic [DATA_WIDTH-1:0]   rf [DEPTH];
    logic [DEPTH-1:0]        busy;
    logic [DEPTH-1:0]        busy_next;

    logic                    run;
    logic                    wr0;
    logic                    wr1;

    // Register 0 is hardwired when ZERO_REG is set, so writes to it are
    // dropped here and never reach the array or the scoreboard.
    assign run   = (state == RUN);
    assign wr0   = run && wen0 && !(ZERO_EN && (waddr0 == '0));
    assign wr1   = run && wen1 && !(ZERO_EN && (waddr1 == '0));
    assign ready = ready_q;

    // Next scoreboard value: writes retire a producer, a new set_busy wins.
    always_comb begin
        busy_next = busy;
        if (wr0) begin
            busy_next[waddr0] = 1'b0;
        end
        if (wr1) begin
            busy_next[waddr1] = 1'b0;
        end
        if (run && set_busy) begin
            busy_next[busy_addr] = 1'b1;
        end
        if (ZERO_EN) begin
            busy_next[0] = 1'b0;
        end
    end

    // Control FSM: clear sequencer, ready flag and busy scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            cnt     <= '0;
            ready_q <= 1'b0;
            busy    <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == {ADDR_WIDTH{1'b1}}) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    busy <= busy_next;
                end
                default: begin
                    state   <= CLEAR;
                    cnt     <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: zero-fill during clear, then port 0 followed by port 1
    // so that port 1 takes the register on an address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                rf[cnt] <= '0;
            end else begin
                if (wr0) begin
                    rf[waddr0] <= wdata0;
                end
                if (wr1) begin
                    rf[waddr1] <= wdata1;
                end
            end
        end
    end

    // Read port A with optional same-cycle forwarding; silent until ready.
    always_comb begin
        rdata1 = '0;
        busy1  = 1'b0;
        if (run) begin
            if (!(ZERO_EN && (raddr1 == '0))) begin
                rdata1 = rf[raddr1];
            end
            busy1 = busy[raddr1];
`ifdef RF_BYPASS_EN
            if (wr1 && (waddr1 == raddr1)) begin
                rdata1 = wdata1;
            end else if (wr0 && (waddr0 == raddr1)) begin
                rdata1 = wdata0;
            end
            if (((wr0 && (waddr0 == raddr1)) || (wr1 && (waddr1 == raddr1)))
                && !(set_busy && (busy_addr == raddr1))) begin
                busy1 = 1'b0;
            end
`endif
        end
    end

    // Read port B, identical to port A.
    always_comb begin
        rdata2 = '0;
        busy2  = 1'b0;
        if (run) begin
            if (!(ZERO_EN && (raddr2 == '0))) begin
                rdata2 = rf[raddr2];
            end
            busy2 = busy[raddr2];
`ifdef RF_BYPASS_EN
            if (wr1 && (waddr1 == raddr2)) begin
                rdata2 = wdata1;
            end else if (wr0 && (waddr0 == raddr2)) begin
                rdata2 = wdata0;
            end
            if (((wr0 && (waddr0 == raddr2)) || (wr1 && (waddr1 == raddr2)))
                && !(set_busy && (busy_addr == raddr2))) begin
                busy2 = 1'b0;
            end
`endif
        end
    end

endmodule

// File: doc/reg_file_bypass.md
Name: reg_file_bypass

Overview:
Parametrised 2-write/2-read register file for the MIPS core datapath. It adds a self-clearing reset sequencer, write-port priority and a per-register busy scoreboard for hazard detection. Same-cycle write-to-read forwarding is optional. It sits between decode (read ports, scoreboard) and writeback/memory return (write ports).

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy; 0 = register 0 is ordinary

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
ready  out  1  1 = clear sequence complete, file usable
wen0  in  1  write enable, port 0 (writeback)
waddr0  in  ADDR_WIDTH  write address, port 0
wdata0  in  DATA_WIDTH  write data, port 0
wen1  in  1  write enable, port 1 (load return)
waddr1  in  ADDR_WIDTH  write address, port 1
wdata1  in  DATA_WIDTH  write data, port 1
raddr1  in  ADDR_WIDTH  read address A
rdata1  out  DATA_WIDTH  read data A, combinational
raddr2  in  ADDR_WIDTH  read address B
rdata2  out  DATA_WIDTH  read data B, combinational
set_busy  in  1  mark busy_addr as pending producer
busy_addr  in  ADDR_WIDTH  register to mark busy
busy1  out  1  register raddr1 is busy
busy2  out  1  register raddr2 is busy

Behaviour:
- States: CLEAR, RUN. 2-bit-or-less state register, plus clear counter cnt[ADDR_WIDTH-1:0].
- rst high at an edge: state<=CLEAR, cnt<=0, all busy bits<=0, ready<=0. rst overrides everything, including mid-clear (the counter restarts at 0).
- CLEAR, rst low: each edge writes rf[cnt]<=0 and cnt<=cnt+1. On the edge that clears index DEPTH-1: state<=RUN, ready<=1. ready therefore rises exactly DEPTH edges after the first edge with rst low. cnt wrap to 0 is harmless.
- During CLEAR: wen0/wen1/set_busy ignored; rdata1=rdata2=0; busy1=busy2=0.
- RUN writes: on an edge, wenN && !(ZERO_REG && waddrN==0) writes rf[waddrN]<=wdataN.
- Both ports writing the same address in RUN: port 1 wins.
- Reads: rdataN = rf[raddrN], or 0 when ZERO_REG && raddrN==0. No read latency.
- Scoreboard (DEPTH bits), updated in RUN only:
  - A valid write from either port clears busy[waddr].
  - set_busy sets busy[busy_addr]. Set and clear on the same address in the same cycle: set wins (new producer).
  - ZERO_REG: busy[0] is constant 0.
- busyN = busy[raddrN], combinational from registered state (no bypass of same-cycle set/clear).
- Reset values: ready=0, busy1=busy2=0, rdata1=rdata2=0 (forced during CLEAR).

Optional Feature:
RF_BYPASS_EN
- Defined: in RUN, if a valid write this cycle targets raddrN, rdataN returns that write's data (port 1 over port 0); busyN also reads 0 for that address unless set_busy targets it the same cycle.
- Undefined: rdataN and busyN reflect stored state only; a write becomes visible the cycle after its edge.

Test Plan:
- rst high 2 cycles, then low -> ready=0 for exactly 32 edges and 1 after; every address reads 0; a wen0 issued during CLEAR has no effect.
- RUN, wen0 waddr0=5 wdata0=0xDEADBEEF -> next cycle raddr1=5 gives 0xDEADBEEF. Same-cycle read gives old value (0) without RF_BYPASS_EN, 0xDEADBEEF with it.
- wen0 and wen1 both to addr 7, data 0x11 / 0x22 -> rdata reads 0x22. wen1 to addr 0 with 0xFFFF (ZERO_REG=1) -> reads 0.
- set_busy addr 9 -> busy1=1 for raddr1=9. Then wen1 addr 9 -> busy clears next cycle. set_busy and wen0 on addr 9 in the same cycle -> stays busy.
- rst reasserted after 10 CLEAR cycles, released -> ready rises 32 edges after release. A value written before reset reads 0 afterwards; all busy bits are 0.
